// File: rtl/seq_bls_subtractor_if.sv
// rtl/seq_bls_subtractor_if.sv - operand/result handshake bundle for seq_bls_subtractor
interface seq_bls_subtractor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] D;
   logic             bout;
   logic             ovf;
   logic             zero;

   modport master (
      output in_valid, A, B, bin, out_ready,
      input  in_ready, out_valid, D, bout, ovf, zero
   );

   modport slave (
      input  in_valid, A, B, bin, out_ready,
      output in_ready, out_valid, D, bout, ovf, zero
   );
endinterface

// File: rtl/seq_bls_subtractor.sv
// rtl/seq_bls_subtractor.sv - multi-cycle subtractor, one 4-bit borrow-lookahead slice per cycle
module seq_bls_subtractor #(
   parameter int WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst,
   seq_bls_subtractor_if.slave bus
);
   localparam int NSLICE = WIDTH / 4;
   localparam int IW     = $clog2(NSLICE + 1);
   localparam int MSB    = WIDTH - 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] a_q, b_q, d_q, d_next;
   logic             borrow_q, bout_q, ovf_q, zero_q;
   logic             rdy, vld;
   logic [IW+1:0]    sh;
   logic [3:0]       sa, sb, sdiff;
   logic             sbout;

   // Every borrow is a flat sum of products of g/p/c0, so no ripple within the slice.
   function automatic logic [4:0] bls4(input logic [3:0] a, input logic [3:0] b, input logic c0);
      logic [3:0] g, p;
      logic [4:0] c;
      g    = ~a & b;
      p    = ~(a ^ b);
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], a ^ b ^ c[3:0]};
   endfunction

   always_comb begin
      sh             = {idx, 2'b00};
      sa             = 4'(a_q >> sh);
      sb             = 4'(b_q >> sh);
      {sbout, sdiff} = bls4(sa, sb, borrow_q);
      d_next         = (d_q & ~(WIDTH'(4'hF) << sh)) | (WIDTH'(sdiff) << sh);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      rdy        = 1'b0;
      vld        = 1'b0;
      case (state)
         IDLE: begin
            rdy = 1'b1;
            if (bus.in_valid) state_next = RUN;
         end
         RUN: begin
            if (idx == LAST) state_next = DONE;
         end
         DONE: begin
            vld = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // bin is parked in the slice borrow register so slice 0 needs no special case.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         d_q      <= '0;
         idx      <= '0;
         borrow_q <= 1'b0;
         bout_q   <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q      <= bus.A;
                  b_q      <= bus.B;
                  borrow_q <= bus.bin;
                  idx      <= '0;
               end
            end
            RUN: begin
               d_q      <= d_next;
               borrow_q <= sbout;
               idx      <= idx + IW'(1);
               if (idx == LAST) begin
                  bout_q <= sbout;
                  ovf_q  <= (a_q[MSB] != b_q[MSB]) && (d_next[MSB] != a_q[MSB]);
                  zero_q <= (d_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld;
   assign bus.D         = d_q;
   assign bus.bout      = bout_q;
   assign bus.ovf       = ovf_q;
   assign bus.zero      = zero_q;
endmodule
